adc_trig_capture: RTL and testbench
===================================

Name: adc_trig_capture

Overview:
Trigger-and-capture controller sitting between the HS_AD9481_IN merged-sample output and the ADC FIFO write port, all in the sys_clk domain.
- Watches the packed dual-sample ADC word for a programmable level crossing.
- Writes a fixed-length burst into the FIFO starting at the trigger word.
- Signals completion so the UART/SPI side can drain the FIFO.
- Provides auto-trigger on timeout and FIFO-overflow protection.

Parameters:
CAPTURE_LEN, 4096, words written per capture (each word = 2 samples); valid range 1..FIFO_DEPTH-4
FIFO_DEPTH, 8192, FIFO word depth; wrusedw width = log2(FIFO_DEPTH)
TIMEOUT, 1250000, sys_clk cycles spent in ARMED before an auto-trigger (10 ms at 125 MHz)
UW, 13, width of wrusedw

Ports:
clk  in  1  sys_clk (ADC clock / 2)
rst_n  in  1  reset; synchronous, active-low
adc_in  in  16  merged ADC word; [7:0] = older sample A, [15:8] = newer sample B; unsigned offset binary
arm  in  1  one-cycle pulse; request a new capture
trig_level  in  8  trigger threshold, sampled at arm
trig_slope  in  1  0 = rising crossing, 1 = falling crossing; sampled at arm
auto_en  in  1  1 = force trigger on timeout; sampled at arm
wrusedw  in  UW  FIFO write-side fill level
wrempty  in  1  FIFO write-side empty flag
fifo_wr  out  1  FIFO write request
fifo_in  out  16  FIFO write data
busy  out  1  high in ARMED, CAPTURE and DRAIN
done  out  1  one-cycle pulse when the last capture word is written
auto_trig  out  1  sticky; this capture was forced by timeout; cleared on accepted arm
overflow  out  1  sticky; at least one word was dropped because the FIFO was near full; cleared on accepted arm

Behaviour:
- Reset, sampled on posedge clk with rst_n = 0: state IDLE; fifo_wr = 0; fifo_in = 0; busy = 0; done = 0; auto_trig = 0; overflow = 0; all counters = 0; pipeline registers = 0.
- Reset mid-capture aborts the capture immediately. Words already written stay in the FIFO; this block does not flush the FIFO.
- Pipeline:
  - d1 <= adc_in every cycle.
  - prevB <= d1[15:8] every cycle.
- Crossing detect (combinational on d1, level L, rising slope):
  - hit = (prevB < L && d1[7:0] >= L) || (d1[7:0] < L && d1[15:8] >= L).
  - Falling slope: same expression with the comparisons inverted (> L, <= L).
  - All comparisons are unsigned.
- States:
  - IDLE:
    - arm=1 && wrempty=1: latch L, slope and auto_en; clear the sticky flags; clear the timeout counter; go to ARMED.
    - arm while wrempty=0: ignored.
  - ARMED:
    - Timeout counter increments every cycle.
    - hit=1: go to CAPTURE.
    - Else if auto_en=1 and counter == TIMEOUT-1: set auto_trig, go to CAPTURE.
    - If hit and timeout coincide, hit wins and auto_trig stays 0.
    - auto_en=0: the block waits indefinitely.
  - Entry into CAPTURE (registered on the same edge as the state change):
    - fifo_wr <= 1 and fifo_in <= d1 (the trigger word).
    - Word counter <= 1.
    - Latency: the trigger word appears on fifo_in 2 cycles after it was on adc_in.
  - CAPTURE:
    - Each cycle: fifo_in <= d1; fifo_wr <= 1; counter++.
    - Writes are contiguous, one per cycle, with no gaps except overflow drops.
    - When the word with counter == CAPTURE_LEN is written: done pulses in the same cycle as that fifo_wr; go to DRAIN. fifo_wr is 0 from the next cycle.
    - CAPTURE_LEN = 1: done pulses alongside the entry write; go straight to DRAIN.
  - Overflow guard (any cycle a write is due):
    - If wrusedw >= FIFO_DEPTH-2: force fifo_wr=0 and set overflow.
    - The word counter still advances, so the capture duration is fixed at CAPTURE_LEN cycles.
  - DRAIN:
    - Wait for wrempty=1, then go to IDLE.
    - arm is ignored in DRAIN.
- busy = (state != IDLE), registered.
- An arm pulse in ARMED or CAPTURE is ignored and does not restart the capture.

Test Plan:
- Rising trigger: L=0x80, slope=0, CAPTURE_LEN=16; ramp A/B from 0x00 upward by 1 per sample; arm -> first fifo_in = word whose A or B first reaches 0x80, 2 cycles after it was on adc_in; exactly 16 consecutive fifo_wr; done pulses with the 16th write; auto_trig=0.
- Intra-word and cross-word crossings: word {B=0x90,A=0x10} -> hit; prior word B=0x70 followed by A=0x85 -> hit on the second word; falling slope with {B=0x10,A=0x90} -> hit.
- Auto trigger: constant adc_in=0x4040, L=0x80, auto_en=1, TIMEOUT=100 -> CAPTURE entered exactly 100 cycles after arm, auto_trig=1. With auto_en=0 -> busy stays 1 and no fifo_wr after 1000 cycles.
- Overflow: hold wrusedw=FIFO_DEPTH-2 during cycles 5..7 of the capture -> no fifo_wr on those 3 cycles, overflow=1, done still exactly CAPTURE_LEN cycles after entry; next accepted arm clears overflow.
- Arm gating: arm while wrempty=0 -> stays IDLE; arm during CAPTURE -> no restart and the write count is unchanged; arm in DRAIN ignored; IDLE reached only after wrempty=1.
- Reset mid-capture: assert rst_n=0 for 1 cycle at word 7 -> next cycle fifo_wr=0, busy=0, all flags 0; a fresh arm works normally.

Source files
------------

// File: rtl/adc_trig_capture.sv
// Trigger-and-capture controller: watches the packed dual-sample ADC stream for a
// level crossing and writes a fixed-length burst into the ADC FIFO.
module adc_trig_capture #(
    parameter int CAPTURE_LEN = 4096,
    parameter int FIFO_DEPTH  = 8192,
    parameter int TIMEOUT     = 1250000,
    parameter int UW          = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   adc_in,
    input  logic          arm,
    input  logic [7:0]    trig_level,
    input  logic          trig_slope,
    input  logic          auto_en,
    input  logic [UW-1:0] wrusedw,
    input  logic          wrempty,
    output logic          fifo_wr,
    output logic [15:0]   fifo_in,
    output logic          busy,
    output logic          done,
    output logic          auto_trig,
    output logic          overflow
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WW = (CAPTURE_LEN > 1) ? $clog2(CAPTURE_LEN + 1) : 1;
    localparam logic [31:0] FULL_LVL = 32'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_d1;
    logic [7:0]    r_prev_b;
    logic [7:0]    r_lvl;
    logic          r_slope, r_auto_en;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic [WW-1:0] r_wcnt, w_wcnt_nxt;
    logic          r_fifo_wr, w_wr_nxt;
    logic [15:0]   r_fifo_in, w_in_nxt;
    logic          r_busy, r_done, w_done_nxt;
    logic          r_auto_trig, w_auto_nxt;
    logic          r_overflow, w_ovf_nxt;
    logic          w_latch, w_wr_due, w_full;
    logic          w_rise, w_fall, w_hit;
    logic [7:0]    w_a, w_b;

    // Sample A is older than sample B, so a crossing can sit between the previous
    // word's B and this word's A, or between A and B of the same word.
    assign w_a    = r_d1[7:0];
    assign w_b    = r_d1[15:8];
    assign w_rise = (r_prev_b < r_lvl && w_a >= r_lvl) || (w_a < r_lvl && w_b >= r_lvl);
    assign w_fall = (r_prev_b > r_lvl && w_a <= r_lvl) || (w_a > r_lvl && w_b <= r_lvl);
    assign w_hit  = r_slope ? w_fall : w_rise;
    assign w_full = 32'(wrusedw) >= FULL_LVL;

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_wcnt_nxt  = r_wcnt;
        w_wr_nxt    = 1'b0;
        w_in_nxt    = r_fifo_in;
        w_done_nxt  = 1'b0;
        w_auto_nxt  = r_auto_trig;
        w_ovf_nxt   = r_overflow;
        w_latch     = 1'b0;
        w_wr_due    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm && wrempty) begin
                    w_latch     = 1'b1;
                    w_auto_nxt  = 1'b0;
                    w_ovf_nxt   = 1'b0;
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                w_tcnt_nxt = r_tcnt + TW'(1);
                if (w_hit || (r_auto_en && r_tcnt == TW'(TIMEOUT - 1))) begin
                    if (!w_hit)
                        w_auto_nxt = 1'b1;
                    w_wr_due    = 1'b1;
                    w_wcnt_nxt  = WW'(1);
                    w_done_nxt  = (CAPTURE_LEN == 1);
                    w_state_nxt = (CAPTURE_LEN == 1) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_wr_due   = 1'b1;
                w_wcnt_nxt = r_wcnt + WW'(1);
                if (r_wcnt == WW'(CAPTURE_LEN - 1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wrempty)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A dropped word still consumes a slot so the capture window stays fixed.
        if (w_wr_due) begin
            w_in_nxt = r_d1;
            w_wr_nxt = !w_full;
            if (w_full)
                w_ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_d1        <= '0;
            r_prev_b    <= '0;
            r_lvl       <= '0;
            r_slope     <= 1'b0;
            r_auto_en   <= 1'b0;
            r_tcnt      <= '0;
            r_wcnt      <= '0;
            r_fifo_wr   <= 1'b0;
            r_fifo_in   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_auto_trig <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_d1        <= adc_in;
            r_prev_b    <= r_d1[15:8];
            r_tcnt      <= w_tcnt_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_fifo_wr   <= w_wr_nxt;
            r_fifo_in   <= w_in_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_auto_trig <= w_auto_nxt;
            r_overflow  <= w_ovf_nxt;
            if (w_latch) begin
                r_lvl     <= trig_level;
                r_slope   <= trig_slope;
                r_auto_en <= auto_en;
            end
        end
    end

    assign fifo_wr   = r_fifo_wr;
    assign fifo_in   = r_fifo_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign auto_trig = r_auto_trig;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture: trigger detection, latency, burst length,
// auto trigger, overflow drops, arm gating and mid-capture reset.
module tb_adc_trig_capture;

    localparam int CL = 16;
    localparam int FD = 8192;
    localparam int TO = 100;
    localparam int UW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   adc_in;
    logic          arm;
    logic [7:0]    trig_level;
    logic          trig_slope;
    logic          auto_en;
    logic [UW-1:0] wrusedw;
    logic          wrempty;
    logic          fifo_wr;
    logic [15:0]   fifo_in;
    logic          busy, done, auto_trig, overflow;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, nwr = 0, ndone = 0;
    int first_cyc = 0, last_cyc = 0, done_cyc = 0;
    int t0;
    logic [15:0] first_w, last_w;

    adc_trig_capture #(
        .CAPTURE_LEN(CL), .FIFO_DEPTH(FD), .TIMEOUT(TO), .UW(UW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adc_in(adc_in), .arm(arm),
        .trig_level(trig_level), .trig_slope(trig_slope), .auto_en(auto_en),
        .wrusedw(wrusedw), .wrempty(wrempty), .fifo_wr(fifo_wr), .fifo_in(fifo_in),
        .busy(busy), .done(done), .auto_trig(auto_trig), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are observed on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (fifo_wr === 1'b1) begin
            nwr++;
            if (nwr == 1) begin
                first_cyc = cyc;
                first_w   = fifo_in;
            end
            last_cyc = cyc;
            last_w   = fifo_in;
        end
        if (done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
        end
    endtask

    task automatic clr();
        nwr = 0; ndone = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0;
        first_w = '0; last_w = '0;
    endtask

    task automatic do_arm(input logic [7:0] lvl, input logic slope, input logic ae);
        trig_level = lvl; trig_slope = slope; auto_en = ae;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic settle(input logic [15:0] w);
        adc_in = w;
        tick();
        tick();
    endtask

    task automatic run_to_done(input string tag, input int lim);
        for (int i = 0; i < lim && ndone == 0; i++) tick();
        check(tag, 32'(ndone != 0), 32'd1);
    endtask

    task automatic run_to_idle(input string tag, input int lim);
        for (int i = 0; i < lim && busy !== 1'b0; i++) tick();
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_trig();
        adc_in = 16'h9010;
        tick();
        adc_in = 16'h1010;
    endtask

    initial begin
        rst_n = 1'b0; adc_in = 16'h0100; arm = 1'b0; trig_level = 8'h80;
        trig_slope = 1'b0; auto_en = 1'b0; wrusedw = '0; wrempty = 1'b1;
        tick(); tick();
        check("rst_fifo_wr", 32'(fifo_wr), 0);
        check("rst_fifo_in", 32'(fifo_in), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_flags", {30'd0, auto_trig, overflow}, 0);
        rst_n = 1'b1;
        tick();

        // Rising ramp: A=2j, B=2j+1; word j=64 is the first with A at 0x80.
        clr();
        do_arm(8'h80, 1'b0, 1'b0);
        check("ramp_armed_busy", 32'(busy), 1);
        for (int j = 0; j < 100; j++) begin
            adc_in = {8'(2*j+1), 8'(2*j)};
            if (j == 64) t0 = cyc;
            tick();
        end
        check("ramp_first_word", 32'(first_w), 32'h8180);
        check("ramp_latency", 32'(first_cyc - t0), 2);
        check("ramp_nwr", 32'(nwr), CL);
        check("ramp_contig", 32'(last_cyc - first_cyc), CL - 1);
        check("ramp_last_word", 32'(last_w), 32'h9F9E);
        check("ramp_ndone", 32'(ndone), 1);
        check("ramp_done_with_last", 32'(done_cyc - last_cyc), 0);
        check("ramp_flags", {30'd0, auto_trig, overflow}, 0);
        check("ramp_idle", 32'(busy), 0);

        // Intra-word crossing {B=0x90,A=0x10}.
        settle(16'h1010); clr();
        do_arm(8'h80, 1'b0, 1'b0);
        tick(); tick();
        pulse_trig();
        run_to_done("intra_done", 40);
        check("intra_first_word", 32'(first_w), 32'h9010);
        check("intra_nwr", 32'(nwr), CL);
        run_to_idle("intra_idle", 10);

        // Cross-word crossing: prior B=0x70, then A=0x85.
        settle(16'h1010); clr();
        do_arm(8'h80, 1'b0, 1'b0);
        tick();
        adc_in = 16'h7060; tick();
        adc_in = 16'h8685; tick();
        adc_in = 16'h1010;
        run_to_done("cross_done", 40);
        check("cross_first_word", 32'(first_w), 32'h8685);
        run_to_idle("cross_idle", 10);

        // Falling crossing {B=0x10,A=0x90}.
        settle(16'hF0F0); clr();
        do_arm(8'h80, 1'b1, 1'b0);
        tick(); tick();
        adc_in = 16'h1090; tick();
        adc_in = 16'hF0F0;
        run_to_done("fall_done", 40);
        check("fall_first_word", 32'(first_w), 32'h1090);
        run_to_idle("fall_idle", 10);

        // Auto trigger after TIMEOUT cycles in ARMED.
        settle(16'h4040); clr();
        t0 = cyc;
        do_arm(8'h80, 1'b0, 1'b1);
        run_to_done("auto_done", 200);
        check("auto_entry_cycle", 32'(first_cyc - t0), TO + 1);
        check("auto_trig_set", 32'(auto_trig), 1);
        check("auto_first_word", 32'(first_w), 32'h4040);
        check("auto_nwr", 32'(nwr), CL);
        run_to_idle("auto_idle", 10);

        // auto_en=0: waits indefinitely; arm clears the sticky auto flag.
        clr();
        do_arm(8'h80, 1'b0, 1'b0);
        check("noauto_flag_cleared", 32'(auto_trig), 0);
        for (int i = 0; i < 1000; i++) tick();
        check("noauto_busy", 32'(busy), 1);
        check("noauto_nwr", 32'(nwr), 0);
        pulse_trig();
        run_to_done("noauto_done", 40);
        check("noauto_hit_flag", 32'(auto_trig), 0);
        run_to_idle("noauto_idle", 10);

        // Overflow: FIFO near full for the slots of words 5..7.
        settle(16'h1010); clr();
        do_arm(8'h80, 1'b0, 1'b0);
        tick();
        t0 = cyc;
        for (int k = 0; k < 25; k++) begin
            adc_in  = (k == 0) ? 16'h9010 : 16'h1010;
            wrusedw = (k >= 5 && k <= 7) ? UW'(FD - 2) : '0;
            tick();
        end
        wrusedw = '0;
        check("ovf_first_cycle", 32'(first_cyc - t0), 2);
        check("ovf_nwr", 32'(nwr), CL - 3);
        check("ovf_ndone", 32'(ndone), 1);
        check("ovf_done_cycle", 32'(done_cyc - t0), CL + 1);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_idle", 32'(busy), 0);
        clr();
        do_arm(8'h80, 1'b0, 1'b0);
        check("ovf_cleared_on_arm", 32'(overflow), 0);
        pulse_trig();
        run_to_done("ovf_rearm_done", 40);
        check("ovf_rearm_nwr", 32'(nwr), CL);
        run_to_idle("ovf_rearm_idle", 10);

        // Arm gating.
        wrempty = 1'b0;
        do_arm(8'h80, 1'b0, 1'b0);
        check("gate_nonempty_idle", 32'(busy), 0);
        tick();
        check("gate_nonempty_idle2", 32'(busy), 0);
        wrempty = 1'b1; clr();
        do_arm(8'h80, 1'b0, 1'b0);
        check("gate_armed", 32'(busy), 1);
        wrempty = 1'b0;
        tick();
        pulse_trig();
        for (int i = 0; i < 10 && nwr < 3; i++) tick();
        arm = 1'b1; tick(); arm = 1'b0;
        run_to_done("gate_cap_done", 40);
        check("gate_cap_nwr", 32'(nwr), CL);
        check("gate_cap_ndone", 32'(ndone), 1);
        tick(); tick(); tick();
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("gate_drain_hold", 32'(busy), 1);
        check("gate_drain_nwr", 32'(nwr), CL);
        wrempty = 1'b1;
        tick();
        check("gate_drain_exit", 32'(busy), 0);

        // Reset mid-capture after auto trigger plus one dropped word.
        settle(16'h4040); clr();
        do_arm(8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 200 && nwr < 1; i++) tick();
        wrusedw = UW'(FD - 2); tick(); wrusedw = '0;
        for (int i = 0; i < 30 && nwr < 7; i++) tick();
        check("rstmid_pre_nwr", 32'(nwr), 7);
        check("rstmid_pre_flags", {30'd0, auto_trig, overflow}, 32'h3);
        rst_n = 1'b0;
        tick();
        check("rstmid_fifo_wr", 32'(fifo_wr), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_flags", {29'd0, done, auto_trig, overflow}, 0);
        rst_n = 1'b1;
        tick();
        settle(16'h1010); clr();
        do_arm(8'h80, 1'b0, 1'b0);
        tick();
        pulse_trig();
        run_to_done("rstmid_fresh_done", 40);
        check("rstmid_fresh_first", 32'(first_w), 32'h9010);
        check("rstmid_fresh_nwr", 32'(nwr), CL);
        check("rstmid_fresh_auto", 32'(auto_trig), 0);
        run_to_idle("rstmid_fresh_idle", 10);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
